// File: rtl/ysyx_2022040010_mem_arbiter_pkg.sv
// ============================================================================
// ysyx_2022040010_mem_arbiter_pkg : shared widths, state/owner encodings, grant
// Revision: 1.0
// ============================================================================
`default_nettype none

package ysyx_2022040010_mem_arbiter_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_e;

  // On a tie the requester that was not served last wins.
  function automatic arb_owner_e rr_grant(input logic i_req, input logic d_req,
                                          input arb_owner_e last);
    if (i_req && d_req) begin
      return (last == OWNER_I) ? OWNER_D : OWNER_I;
    end
    return d_req ? OWNER_D : OWNER_I;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_2022040010_mem_arbiter.sv
// ============================================================================
// ysyx_2022040010_mem_arbiter : round-robin I/D cache arbiter onto one bus
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_2022040010_mem_arbiter
  import ysyx_2022040010_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W,
  parameter int MASK_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_req,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic              icache_ready,
  output logic [DATA_W-1:0] icache_rdata,
  input  logic              dcache_req,
  input  logic              dcache_we,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [DATA_W-1:0] dcache_wdata,
  input  logic [MASK_W-1:0] dcache_wmask,
  output logic              dcache_ready,
  output logic [DATA_W-1:0] dcache_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stallreq_for_cache,
  output logic              rw_over
);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  arb_owner_e        last_owner_q, last_owner_d;
  arb_owner_e        grant;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              i_ready_q, i_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              rw_over_q, rw_over_d;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    rdata_d      = rdata_q;
    grant        = rr_grant(icache_req, dcache_req, last_owner_q);

    case (state_q)
      ST_IDLE: begin
        if (icache_req || dcache_req) begin
          owner_d = grant;
          state_d = ST_REQ;
          if (grant == OWNER_D) begin
            we_d    = dcache_we;
            addr_d  = dcache_addr;
            wdata_d = dcache_wdata;
            wmask_d = dcache_wmask;
          end else begin
            we_d    = 1'b0;
            addr_d  = icache_addr;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          state_d = ST_WAIT;
        end
      end
      // Completion of a write is signalled by mem_rvalid too; its data is captured anyway.
      ST_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = mem_rdata;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        last_owner_d = owner_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they leave the flops glitch-free.
    mem_req_d = (state_d == ST_REQ);
    i_ready_d = (state_d == ST_RESP) && (owner_d == OWNER_I);
    d_ready_d = (state_d == ST_RESP) && (owner_d == OWNER_D);
    rw_over_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_I;
      last_owner_q <= OWNER_I;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      rdata_q      <= '0;
      mem_req_q    <= 1'b0;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      rw_over_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      rdata_q      <= rdata_d;
      mem_req_q    <= mem_req_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      rw_over_q    <= rw_over_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign mem_wmask    = wmask_q;
  assign icache_ready = i_ready_q;
  assign dcache_ready = d_ready_q;
  assign icache_rdata = rdata_q;
  assign dcache_rdata = rdata_q;
  assign rw_over      = rw_over_q;

  assign stallreq_for_cache = (icache_req & ~i_ready_q) | (dcache_req & ~d_ready_q);

endmodule

`default_nettype wire

// File: tb/tb_ysyx_2022040010_mem_arbiter.sv
// ============================================================================
// tb_ysyx_2022040010_mem_arbiter : directed self-checking bench for the arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_2022040010_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_ready;
  logic [63:0] icache_rdata;
  logic        dcache_req;
  logic        dcache_we;
  logic [31:0] dcache_addr;
  logic [63:0] dcache_wdata;
  logic [7:0]  dcache_wmask;
  logic        dcache_ready;
  logic [63:0] dcache_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        stallreq_for_cache;
  logic        rw_over;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_2022040010_mem_arbiter dut (
    .clk                (clk),
    .rst                (rst),
    .icache_req         (icache_req),
    .icache_addr        (icache_addr),
    .icache_ready       (icache_ready),
    .icache_rdata       (icache_rdata),
    .dcache_req         (dcache_req),
    .dcache_we          (dcache_we),
    .dcache_addr        (dcache_addr),
    .dcache_wdata       (dcache_wdata),
    .dcache_wmask       (dcache_wmask),
    .dcache_ready       (dcache_ready),
    .dcache_rdata       (dcache_rdata),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_wmask          (mem_wmask),
    .mem_ready          (mem_ready),
    .mem_rvalid         (mem_rvalid),
    .mem_rdata          (mem_rdata),
    .stallreq_for_cache (stallreq_for_cache),
    .rw_over            (rw_over)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Plays the bus side of one transaction: mem_ready for one cycle, mem_rvalid the next.
  task automatic serve(input logic exp_d, input logic exp_we, input logic [31:0] exp_addr,
                       input logic [63:0] exp_wdata, input logic [7:0] exp_wmask,
                       input logic [63:0] rd, input logic drop_after);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL serve_timeout: mem_req=%b required 1 within 20 cycles", mem_req);
      return;
    end
    checks++;
    if (mem_addr !== exp_addr) begin
      errors++;
      $display("FAIL serve_addr: got %h required %h", mem_addr, exp_addr);
    end
    checks++;
    if (mem_we !== exp_we) begin
      errors++;
      $display("FAIL serve_we: got %b required %b", mem_we, exp_we);
    end
    checks++;
    if (mem_wmask !== exp_wmask) begin
      errors++;
      $display("FAIL serve_wmask: got %h required %h", mem_wmask, exp_wmask);
    end
    if (exp_we) begin
      checks++;
      if (mem_wdata !== exp_wdata) begin
        errors++;
        $display("FAIL serve_wdata: got %h required %h", mem_wdata, exp_wdata);
      end
    end
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || rw_over !== 1'b0) begin
      errors++;
      $display("FAIL serve_wait: mem_req=%b rw_over=%b required 0 0", mem_req, rw_over);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    tick;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    checks++;
    if (dcache_ready !== exp_d || icache_ready !== !exp_d || rw_over !== 1'b1) begin
      errors++;
      $display("FAIL serve_resp: i_ready=%b d_ready=%b rw_over=%b required %b %b 1",
               icache_ready, dcache_ready, rw_over, !exp_d, exp_d);
    end
    if (!exp_we) begin
      checks++;
      if ((exp_d ? dcache_rdata : icache_rdata) !== rd) begin
        errors++;
        $display("FAIL serve_rdata: got %h required %h",
                 exp_d ? dcache_rdata : icache_rdata, rd);
      end
    end
    if (drop_after) begin
      if (exp_d) dcache_req = 1'b0;
      else       icache_req = 1'b0;
    end
    tick;
    checks++;
    if (icache_ready !== 1'b0 || dcache_ready !== 1'b0 || rw_over !== 1'b0) begin
      errors++;
      $display("FAIL serve_pulse_len: i_ready=%b d_ready=%b rw_over=%b required 0 0 0",
               icache_ready, dcache_ready, rw_over);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    icache_req = 1'b1;
    tick;
    tick;
    checks++;
    if (mem_req !== 1'b0 || rw_over !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: mem_req=%b rw_over=%b required 0 0", mem_req, rw_over);
    end
    checks++;
    if (icache_ready !== 1'b0 || dcache_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: i=%b d=%b required 0 0", icache_ready, dcache_ready);
    end
    checks++;
    if (stallreq_for_cache !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_req: got %b required 1", stallreq_for_cache);
    end
    checks++;
    if (icache_rdata !== 64'd0 || mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs: rdata=%h addr=%h required 0 0", icache_rdata, mem_addr);
    end
    icache_req = 1'b0;
    #1;
    checks++;
    if (stallreq_for_cache !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall_idle: got %b required 0", stallreq_for_cache);
    end
    rst = 1'b0;
    tick;
    tick;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req: mem_req=%b required 0", mem_req);
    end
  endtask

  task automatic test_single_iread;
    icache_addr = 32'h8000_0000;
    icache_req  = 1'b1;
    #1;
    checks++;
    if (stallreq_for_cache !== 1'b1) begin
      errors++;
      $display("FAIL iread_stall_high: got %b required 1", stallreq_for_cache);
    end
    tick;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL iread_req: req=%b addr=%h we=%b required 1 80000000 0",
               mem_req, mem_addr, mem_we);
    end
    mem_ready = 1'b1;
    tick;
    mem_ready = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || icache_ready !== 1'b0 || rw_over !== 1'b0) begin
      errors++;
      $display("FAIL iread_wait: req=%b ready=%b rw_over=%b required 0 0 0",
               mem_req, icache_ready, rw_over);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h0000_0013_0000_0297;
    tick;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    checks++;
    if (icache_ready !== 1'b1 || rw_over !== 1'b1 || dcache_ready !== 1'b0) begin
      errors++;
      $display("FAIL iread_resp: i=%b rw_over=%b d=%b required 1 1 0",
               icache_ready, rw_over, dcache_ready);
    end
    checks++;
    if (icache_rdata !== 64'h0000_0013_0000_0297) begin
      errors++;
      $display("FAIL iread_rdata: got %h required 0000001300000297", icache_rdata);
    end
    checks++;
    if (stallreq_for_cache !== 1'b0) begin
      errors++;
      $display("FAIL iread_stall_drop: got %b required 0", stallreq_for_cache);
    end
    icache_req = 1'b0;
    tick;
    checks++;
    if (icache_ready !== 1'b0 || rw_over !== 1'b0) begin
      errors++;
      $display("FAIL iread_one_cycle: ready=%b rw_over=%b required 0 0", icache_ready, rw_over);
    end
    checks++;
    if (icache_rdata !== 64'h0000_0013_0000_0297) begin
      errors++;
      $display("FAIL iread_rdata_hold: got %h required 0000001300000297", icache_rdata);
    end
  endtask

  task automatic test_tie;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    dcache_we    = 1'b1;
    dcache_addr  = 32'h8000_1000;
    dcache_wdata = 64'h0000_0000_DEAD_BEEF;
    dcache_wmask = 8'h0F;
    dcache_req   = 1'b1;
    icache_addr  = 32'h8000_0000;
    icache_req   = 1'b1;
    tick;
    serve(1'b1, 1'b1, 32'h8000_1000, 64'h0000_0000_DEAD_BEEF, 8'h0F, 64'h55, 1'b1);
    checks++;
    if (stallreq_for_cache !== 1'b1) begin
      errors++;
      $display("FAIL tie_stall_pending: got %b required 1", stallreq_for_cache);
    end
    serve(1'b0, 1'b0, 32'h8000_0000, 64'h0, 8'h00, 64'h1111_2222_3333_4444, 1'b1);
    checks++;
    if (stallreq_for_cache !== 1'b0) begin
      errors++;
      $display("FAIL tie_stall_clear: got %b required 0", stallreq_for_cache);
    end
    dcache_we    = 1'b0;
    dcache_wmask = 8'h00;
  endtask

  task automatic test_fairness;
    // Last served is I, so the alternation starts with D.
    dcache_addr = 32'h8000_2000;
    icache_addr = 32'h8000_0100;
    dcache_req  = 1'b1;
    icache_req  = 1'b1;
    serve(1'b1, 1'b0, 32'h8000_2000, 64'h0, 8'h00, 64'hA1, 1'b0);
    serve(1'b0, 1'b0, 32'h8000_0100, 64'h0, 8'h00, 64'hB2, 1'b0);
    serve(1'b1, 1'b0, 32'h8000_2000, 64'h0, 8'h00, 64'hC3, 1'b0);
    serve(1'b0, 1'b0, 32'h8000_0100, 64'h0, 8'h00, 64'hD4, 1'b1);
    dcache_req = 1'b0;
    tick;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++;
      $display("FAIL fair_quiet: mem_req=%b required 0", mem_req);
    end
  endtask

  task automatic test_backpressure;
    icache_addr = 32'h8000_0040;
    icache_req  = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h8000_0040) begin
        errors++;
        $display("FAIL bp_stable[%0d]: req=%b addr=%h required 1 80000040", i, mem_req, mem_addr);
      end
      checks++;
      if (icache_ready !== 1'b0 || dcache_ready !== 1'b0 || rw_over !== 1'b0) begin
        errors++;
        $display("FAIL bp_no_ready[%0d]: i=%b d=%b rw=%b required 0 0 0",
                 i, icache_ready, dcache_ready, rw_over);
      end
      icache_addr = 32'h9000_0000 + 32'(i);
      tick;
    end
    serve(1'b0, 1'b0, 32'h8000_0040, 64'h0, 8'h00, 64'hFEED, 1'b1);
  endtask

  task automatic test_drop_midway;
    dcache_we   = 1'b0;
    dcache_addr = 32'h8000_3000;
    dcache_req  = 1'b1;
    tick;
    dcache_req = 1'b0;
    serve(1'b1, 1'b0, 32'h8000_3000, 64'h0, 8'h00, 64'h1234_5678, 1'b0);
  endtask

  task automatic test_reset_in_wait;
    icache_addr = 32'h8000_0080;
    icache_req  = 1'b1;
    tick;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rstw_req: mem_req=%b required 1", mem_req);
    end
    mem_ready = 1'b1;
    tick;
    mem_ready  = 1'b0;
    rst        = 1'b1;
    icache_req = 1'b0;
    tick;
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hBAD0_BAD0;
    checks++;
    if (icache_rdata !== 64'd0) begin
      errors++;
      $display("FAIL rstw_rdata_clear: got %h required 0", icache_rdata);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (icache_ready !== 1'b0 || dcache_ready !== 1'b0 || rw_over !== 1'b0 || mem_req !== 1'b0) begin
        errors++;
        $display("FAIL rstw_quiet[%0d]: i=%b d=%b rw=%b req=%b required 0 0 0 0",
                 i, icache_ready, dcache_ready, rw_over, mem_req);
      end
      tick;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    icache_req   = 1'b0;
    icache_addr  = '0;
    dcache_req   = 1'b0;
    dcache_we    = 1'b0;
    dcache_addr  = '0;
    dcache_wdata = '0;
    dcache_wmask = '0;
    mem_ready    = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = '0;
    test_reset;
    test_single_iread;
    test_tie;
    test_fairness;
    test_backpressure;
    test_drop_midway;
    test_reset_in_wait;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
